// File: rtl/alu_wide_seq_if.sv
// Bundle between the wide-ALU sequencer, its control unit and the 16-bit ALU.
// slave = the sequencer itself; master = its surroundings (control unit plus ALU).
interface alu_wide_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         start;
  logic [2:0]   op_sel;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;

  logic [15:0]  alu_a;
  logic [15:0]  alu_b;
  logic [3:0]   alu_op;
  logic         alu_cin;
  logic [15:0]  alu_z;
  logic         alu_cout;

  modport master (
    output start, op_sel, opa, opb, alu_z, alu_cout,
    input  busy, done, result, carry_out, alu_a, alu_b, alu_op, alu_cin
  );

  modport slave (
    input  start, op_sel, opa, opb, alu_z, alu_cout,
    output busy, done, result, carry_out, alu_a, alu_b, alu_op, alu_cin
  );
endinterface

// File: rtl/alu_wide_seq.sv
// Multi-word ADD/SUB/AND/XOR/OR sequencer: walks a 16-bit ALU over WORDS words,
// LSW first, chaining carry/borrow through the ALU's carry-in op variants.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; result/carry_out hold the last operation
// ST_RUN  | one 16-bit word per cycle through the ALU, idx = current word
// ST_DONE | one-cycle done pulse; start ignored
module alu_wide_seq #(
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_wide_seq_if.slave bus
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_op;
  logic [W-1:0]  r_result;
  logic          r_carry_out;
  logic          r_busy;
  logic          r_done;

  logic [IW+3:0] w_lsb;
  logic          w_run;
  logic          w_first;
  logic [3:0]    w_op;

  assign w_lsb   = {r_idx, 4'b0000};
  assign w_run   = (r_state == ST_RUN);
  assign w_first = (r_idx == '0);

  // Word 0 uses the carry-out-only variants so nothing leaks in from a previous op.
  always_comb begin
    w_op = 4'hf;
    case (r_op)
      OP_ADD:  w_op = w_first ? 4'h2 : 4'h6;
      OP_SUB:  w_op = w_first ? 4'h3 : 4'h7;
      OP_AND:  w_op = 4'h8;
      OP_XOR:  w_op = 4'h9;
      OP_OR:   w_op = 4'ha;
      default: w_op = 4'hf;
    endcase
  end

  assign bus.alu_a   = w_run ? r_a[w_lsb +: 16] : 16'h0000;
  assign bus.alu_b   = w_run ? r_b[w_lsb +: 16] : 16'h0000;
  assign bus.alu_op  = w_run ? w_op : 4'h0;
  assign bus.alu_cin = w_run ? r_carry : 1'b0;

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 3'd0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a         <= bus.opa;
            r_b         <= bus.opb;
            r_op        <= bus.op_sel;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result[w_lsb +: 16] <= bus.alu_z;
          r_carry               <= bus.alu_cout;
          if (r_idx == LAST_IDX) begin
            // Final carry taken straight from the ALU so it is valid with done.
            r_carry_out <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? bus.alu_cout : 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq: behavioural 16-bit ALU plus a whole-operand
// reference model; directed corner cases followed by randomized operations.
module tb_alu_wide_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_wide_seq_if #(.WORDS(WORDS)) bus ();

  alu_wide_seq #(.WORDS(WORDS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural 16-bit ALU; cout is carry for adds and borrow for subtracts.
  logic [16:0] alu_t;
  always_comb begin
    alu_t = 17'h0;
    case (bus.alu_op)
      4'h2: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'h6: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'h0, bus.alu_cin};
      4'h3: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      4'h7: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {16'h0, bus.alu_cin};
      4'h8: alu_t = {1'b0, bus.alu_a & bus.alu_b};
      4'h9: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
      4'ha: alu_t = {1'b0, bus.alu_a | bus.alu_b};
      default: alu_t = 17'h0;
    endcase
    bus.alu_z    = alu_t[15:0];
    bus.alu_cout = alu_t[16];
  end

  logic [3:0] op_q[$];
  always @(posedge clk) if (bus.alu_op != 4'h0) op_q.push_back(bus.alu_op);

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c);
    logic [W:0] s;
    s = '0;
    r = '0;
    c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a | b;
      default: begin r = '0; c = 1'b0; end
    endcase
  endfunction

  function automatic logic [63:0] exp_ops(input logic [2:0] op);
    logic [63:0] v;
    logic [3:0]  code;
    v = '0;
    for (int i = 0; i < WORDS; i++) begin
      case (op)
        3'd0: code = (i == 0) ? 4'h2 : 4'h6;
        3'd1: code = (i == 0) ? 4'h3 : 4'h7;
        3'd2: code = 4'h8;
        3'd3: code = 4'h9;
        3'd4: code = 4'ha;
        default: code = 4'hf;
      endcase
      v[4*i +: 4] = code;
    end
    return v;
  endfunction

  function automatic logic [63:0] packed_ops();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < op_q.size() && i < 16; i++) v[4*i +: 4] = op_q[i];
    return v;
  endfunction

  // Waits up to a bounded number of edges for done; returns edges counted.
  task automatic wait_done(output int n);
    n = 0;
    while (n < WORDS + 4) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic         ec;
    int           n;
    ref_op(op, a, b, er, ec);
    @(negedge clk);
    op_q.delete();
    bus.start = 1'b1; bus.op_sel = op; bus.opa = a; bus.opb = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.opa    = {$urandom, $urandom};
    bus.opb    = {$urandom, $urandom};
    bus.op_sel = 3'($urandom_range(0, 7));
    wait_done(n);
    chk({tag, " latency"}, W'(n), W'(WORDS));
    chk({tag, " result"}, bus.result, er);
    chk({tag, " carry"}, W'(bus.carry_out), W'(ec));
    chk({tag, " busy"}, W'(bus.busy), W'(1));
    chk({tag, " nops"}, W'(op_q.size()), W'(WORDS));
    chk({tag, " opseq"}, W'(packed_ops()), W'(exp_ops(op)));
    @(posedge clk); #1;
    chk({tag, " done width"}, W'(bus.done), W'(0));
    chk({tag, " idle busy"}, W'(bus.busy), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a1, b1, la, lb, er;
    logic         ec;
    int           n;
    bus.start = 1'b0; bus.op_sel = 3'd0; bus.opa = '0; bus.opb = '0;

    #12;
    chk("rst busy", W'(bus.busy), W'(0));
    chk("rst done", W'(bus.done), W'(0));
    chk("rst result", bus.result, '0);
    chk("rst carry", W'(bus.carry_out), W'(0));
    chk("rst alu_op", W'(bus.alu_op), W'(0));
    chk("rst alu_a", W'(bus.alu_a), W'(0));
    @(negedge clk); rst_n = 1'b1;

    do_op("add16", 3'd0, 64'h0000_0000_0000_FFFF, 64'h1);
    chk("add16 abs", bus.result, 64'h0000_0000_0001_0000);
    do_op("addall", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    chk("addall abs", W'(bus.carry_out), W'(1));
    do_op("sub0", 3'd1, 64'h0, 64'h1);
    chk("sub0 abs", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("sub1", 3'd1, 64'h1_0000, 64'h1);
    chk("sub1 abs", bus.result, 64'h0000_0000_0000_FFFF);
    do_op("xor", 3'd3, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000);
    chk("xor abs", bus.result, 64'hEDCB_5678_6543_DEF0);
    do_op("rsv6", 3'd6, 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FFFF_FFFF);
    do_op("and", 3'd2, 64'hF0F0_1234_FFFF_0000, 64'h0FF0_FFFF_1234_5678);
    do_op("or", 3'd4, 64'hF000_0000_0000_000F, 64'h0F00_0000_1000_00F0);

    // start held high and operands toggled through RUN/DONE
    a1 = 64'h0123_4567_89AB_CDEF; b1 = 64'hFEDC_BA98_7654_3210;
    ref_op(3'd0, a1, b1, er, ec);
    @(negedge clk);
    bus.start = 1'b1; bus.op_sel = 3'd0; bus.opa = a1; bus.opb = b1;
    @(posedge clk);
    for (int k = 1; k <= WORDS + 1; k++) begin
      @(negedge clk);
      bus.opa = ~bus.opa ^ {$urandom, $urandom};
      bus.opb = {$urandom, $urandom};
      @(posedge clk); #1;
      if (k == WORDS) begin
        chk("hold done", W'(bus.done), W'(1));
        chk("hold result", bus.result, er);
        chk("hold carry", W'(bus.carry_out), W'(ec));
      end
      if (k == WORDS + 1) chk("hold no restart", W'(bus.busy), W'(0));
    end
    @(negedge clk);
    la = bus.opa; lb = bus.opb;
    @(posedge clk); #1;
    chk("hold reaccept", W'(bus.busy), W'(1));
    bus.start = 1'b0; bus.opa = '0; bus.opb = '0;
    ref_op(3'd0, la, lb, er, ec);
    wait_done(n);
    chk("reaccept latency", W'(n), W'(WORDS));
    chk("reaccept result", bus.result, er);
    chk("reaccept carry", W'(bus.carry_out), W'(ec));
    @(posedge clk); #1;

    // reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op_sel = 3'd0;
    bus.opa = 64'hFFFF_FFFF_FFFF_FFFF; bus.opb = 64'h1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid rst busy", W'(bus.busy), W'(0));
    chk("mid rst done", W'(bus.done), W'(0));
    chk("mid rst result", bus.result, '0);
    chk("mid rst carry", W'(bus.carry_out), W'(0));
    chk("mid rst alu_op", W'(bus.alu_op), W'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < WORDS + 2; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) n++;
    end
    chk("mid rst no done", W'(n), W'(0));
    do_op("post rst", 3'd0, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = '1;
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 3));
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
- Multi-word arithmetic sequencer: the initiator that drives the 16-bit ALU's a/b/op/cin port and consumes its z/cout.
- Executes WORDS×16-bit ADD/SUB/AND/XOR/OR one 16-bit word per cycle, LSW first.
- Chains carry/borrow between words using the ALU carry-out/carry-in op variants.
- Sits between the core control unit (start/done handshake) and one combinational ALU instance.

Parameters:
- WORDS, 4, number of 16-bit words per operand (legal 1..16); operand width W = 16*WORDS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_sel  in  3  0=ADD, 1=SUB, 2=AND, 3=XOR, 4=OR, 5..7 reserved.
- opa  in  W  operand A; latched when start is accepted.
- opb  in  W  operand B; latched when start is accepted.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result/carry_out valid.
- result  out  W  registered result; held until next accepted start.
- carry_out  out  1  final carry (ADD) or borrow (SUB); 0 for logic ops.
- alu_a  out  16  ALU operand a.
- alu_b  out  16  ALU operand b.
- alu_op  out  4  ALU op code.
- alu_cin  out  1  ALU carry in.
- alu_z  in  16  ALU result.
- alu_cout  in  1  ALU carry out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, carry_q=0.
  - result=0, carry_out=0, busy=0, done=0.
  - Operand latches cleared.
  - Reset mid-RUN aborts immediately; no done pulse; ALU outputs return to idle values.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge → latch opa/opb/op_sel, idx=0, carry_q=0, result=0, go RUN. start=0 → stay.
  - RUN: each edge captures alu_z into result[16*idx +: 16] and alu_cout into carry_q. If idx==WORDS-1 → DONE, else idx+1.
  - DONE: done=1 for exactly one cycle; carry_out = carry_q (ADD/SUB) else 0; next edge → IDLE.
- start is ignored in RUN and DONE: no queuing, no restart. It is first re-sampled in the IDLE cycle after done.
- Latency: start accepted at edge E0; words captured at E1..E_WORDS; done high from E_WORDS to E_WORDS+1. Back-to-back starts give one op per WORDS+2 cycles.
- ALU drive in RUN, combinational from idx:
  - alu_a = latched A word idx; alu_b = latched B word idx.
- ALU op codes by op_sel and word position:
  - ADD: word 0 → 4'h2 (ADDCO); words ≥1 → 4'h6 (ADDCOCI).
  - SUB: word 0 → 4'h3 (SUBCO); words ≥1 → 4'h7 (SUBCOCI).
  - AND → 4'h8; XOR → 4'h9; OR → 4'ha.
  - Reserved op_sel 5..7 → 4'hf; ALU returns 0, so result=0 and carry_out=0. Full latency and done pulse still occur.
- alu_cin = carry_q in RUN. Word 0 always sees carry_q=0.
- WORDS=1: single RUN cycle using the word-0 op.
- Outside RUN: alu_a=0, alu_b=0, alu_op=4'h0, alu_cin=0.
- Changes on opa/opb/op_sel after acceptance have no effect.
- result is never partially visible as valid; only done qualifies it.

Test Plan:
- WORDS=4, ADD: opa=0x0000_0000_0000_FFFF, opb=0x1 → result=0x0000_0000_0001_0000, carry_out=0, done exactly 4 cycles after acceptance edge (at E4), one cycle wide.
- ADD: opa=0xFFFF_FFFF_FFFF_FFFF, opb=0x1 → result=0, carry_out=1. Bench ALU model checks alu_op sequence 2,6,6,6.
- SUB: opa=0, opb=0x1 → result=0xFFFF_FFFF_FFFF_FFFF, carry_out=1. SUB 0x1_0000 − 0x1 → 0x0000_0000_0000_FFFF, carry_out=0. alu_op sequence 3,7,7,7.
- XOR: opa=0x1234_5678_9ABC_DEF0, opb=0xFFFF_0000_FFFF_0000 → 0xEDCB_5678_6543_DEF0, carry_out=0. Reserved op_sel=6 → result=0, done still pulses.
- Pulse start and toggle opa every cycle during RUN/DONE → second start ignored, result reflects first operands, next start accepted only in IDLE.
- Assert rst_n=0 mid-RUN (after 2 words) → busy/done/result/carry_out=0 asynchronously, no done pulse, alu_op=0. Fresh start after release completes correctly.
